// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin N:1 mux arbiter with registered output stage
// Optional burst lock: define MUX_RR_ARBITER_LOCK_EN to hold the grant until req_last.
module mux_rr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;

    logic               hi_found;
    logic [IDX_W-1:0]   hi_idx, lo_idx, win_idx;
    logic [WIDTH-1:0]   sel_data;
    logic               xfer;
    logic               release_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Winner = lowest valid index at or above ptr, else lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDX_W'(i);
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == GRANT && (!out_valid_q || out_ready)) begin
            req_ready = grant_q;
        end
    end

    assign xfer = |(req_valid & req_ready);

`ifdef MUX_RR_ARBITER_LOCK_EN
    assign release_grant = xfer && (|(req_last & grant_q));
`else
    logic unused_last;
    assign unused_last   = ^req_last;
    assign release_grant = xfer;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d     = GRANT;
                    grant_idx_d = win_idx;
                    for (int i = 0; i < N_REQ; i++) begin
                        grant_d[i] = (IDX_W'(i) == win_idx);
                    end
                end
            end
            GRANT: begin
                if (release_grant) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    grant_idx_d = '0;
                    ptr_d       = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A load in the same cycle as a drain keeps the stage full with the new beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int vectors = 0;
    int miscompares = 0;
    int g_q[$];
    logic [7:0] d_q[$];

    mux_rr_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .grant_idx(grant_idx),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic hold_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_last  = 4'hF;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic collect(input int ncyc);
        g_q.delete();
        d_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (grant != 4'b0000) g_q.push_back(int'(grant_idx));
            if (out_valid) d_q.push_back(out_data);
        end
    endtask

    task automatic test_reset();
        hold_reset();
        req_valid = 4'b1111;
        req_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_data, grant, grant_idx, req_ready} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b d=%h g=%b i=%0d r=%b exp all zero",
                     out_valid, out_data, grant, grant_idx, req_ready);
        end
        release_reset();
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        @(posedge clk);
        #1;
        vectors++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2 || req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_first_grant got g=%b i=%0d r=%b exp g=0100 i=2 r=0100", grant, grant_idx, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL reset_first_beat got v=%b d=%h exp v=1 d=a5", out_valid, out_data);
        end
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_grant_released got %b exp 0000", grant);
        end
    endtask

    task automatic test_fairness();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        hold_reset();
        release_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        collect(12);
        vectors++;
        if (g_q.size() < 5 || d_q.size() < 5) begin
            miscompares++;
            $display("FAIL fairness_count got grants=%0d beats=%0d exp >=5 each", g_q.size(), d_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (g_q[k] != exp_g[k] || d_q[k] !== 8'h10 + 8'(exp_g[k])) begin
                    miscompares++;
                    $display("FAIL fairness_%0d got grant=%0d data=%h exp grant=%0d data=%h",
                             k, g_q[k], d_q[k], exp_g[k], 8'h10 + 8'(exp_g[k]));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_g[3] = '{3, 0, 3};
        hold_reset();
        release_reset();
        req_valid = 4'b0100;
        req_data  = 32'h3322_1100;
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = 4'b1001;
        collect(8);
        vectors++;
        if (g_q.size() < 3) begin
            miscompares++;
            $display("FAIL wrap_count got %0d exp >=3", g_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (g_q[k] != exp_g[k]) begin
                    miscompares++;
                    $display("FAIL wrap_%0d got %0d exp %0d", k, g_q[k], exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        hold_reset();
        release_reset();
        req_valid = 4'b0011;
        req_data  = 32'h0000_B1B0;
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'hB0 || req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_%0d got v=%b d=%h r=%b exp v=1 d=b0 r=0000", c, out_valid, out_data, req_ready);
            end
        end
        vectors++;
        if (grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_grant got %b exp 0010", grant);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL unstall_ready got %b exp 0010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hB1) begin
            miscompares++;
            $display("FAIL unstall_beat got v=%b d=%h exp v=1 d=b1", out_valid, out_data);
        end
    endtask

`ifdef MUX_RR_ARBITER_LOCK_EN
    task automatic test_lock();
        int beats = 0;
        hold_reset();
        release_reset();
        req_valid = 4'b0110;
        req_data  = 32'h00C0_A000;
        req_last  = 4'b0000;
        for (int c = 0; c < 20 && beats < 3; c++) begin
            @(negedge clk);
            if (req_valid[1] && req_ready[1]) begin
                vectors++;
                if (grant !== 4'b0010) begin
                    miscompares++;
                    $display("FAIL lock_beat_%0d grant got %b exp 0010", beats, grant);
                end
                beats++;
                @(posedge clk);
                #1;
                req_data[15:8] = 8'hA0 + 8'(beats);
                req_last[1]    = (beats == 2);
                if (beats == 3) req_valid[1] = 1'b0;
            end
        end
        vectors++;
        if (beats != 3 || out_data !== 8'hA2) begin
            miscompares++;
            $display("FAIL lock_burst got beats=%0d d=%h exp beats=3 d=a2", beats, out_data);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL lock_handover got %b exp 0100", grant);
        end
        req_valid = 4'b0000;
        req_last  = 4'hF;
    endtask
`endif

    task automatic test_reset_mid_burst();
        hold_reset();
        release_reset();
        req_valid = 4'b0011;
        req_data  = 32'h0000_D1D0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (out_valid !== 1'b1 || grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL midrst_setup got v=%b g=%b exp v=1 g=0010", out_valid, grant);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || grant !== 4'b0000 || out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_async got v=%b g=%b d=%h exp 0/0000/00", out_valid, grant, out_data);
        end
        release_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_restart got %b exp 0001", grant);
        end
    endtask

    // Every requester keeps its queue presented, so the accepted order is fixed by round-robin alone.
    task automatic test_random(input int round);
        logic [7:0] q[4][$];
        logic [7:0] tmp[4][$];
        logic [7:0] exp_q[$];
        int ptr = 0;
        int cyc = 0;
        int xi;
        hold_reset();
        for (int i = 0; i < 4; i++) begin
            int n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) q[i].push_back(8'($urandom));
            tmp[i] = q[i];
        end
        forever begin
            int w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && tmp[(ptr + k) % 4].size() > 0) w = (ptr + k) % 4;
            end
            if (w < 0) break;
            exp_q.push_back(tmp[w].pop_front());
            ptr = (w + 1) % 4;
        end
        release_reset();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = q[i].size() > 0;
            req_data[i*8 +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
        end
        while (exp_q.size() > 0 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
            vectors++;
            if (!$onehot0(req_ready)) begin
                miscompares++;
                $display("FAIL rand%0d_ready_onehot got %b", round, req_ready);
            end
            if (out_valid && out_ready) begin
                logic [7:0] e = exp_q.pop_front();
                vectors++;
                if (out_data !== e) begin
                    miscompares++;
                    $display("FAIL rand%0d_data got %h exp %h", round, out_data, e);
                end
            end
            xi = -1;
            for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) xi = i;
            @(posedge clk);
            #1;
            if (xi >= 0) void'(q[xi].pop_front());
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = q[i].size() > 0;
                req_data[i*8 +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand%0d_timeout got %0d beats outstanding exp 0", round, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_wrap();
        test_backpressure();
`ifdef MUX_RR_ARBITER_LOCK_EN
        test_lock();
`endif
        test_reset_mid_burst();
        for (int r = 0; r < 4; r++) test_random(r);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for a shared N:1 data mux. Up to N_REQ requesters present valid/data/last; the block picks one requester and drives the mux select. It moves the winner's beats into a single registered output stage with a valid/ready handshake. It sits in front of any shared downstream resource, such as a bus, FIFO or ALU port, that the selector mux feeds.

## Interface
- N_REQ, 4: number of requesters, ≥2.
- WIDTH, 8: data width per requester.
- IDX_W, $clog2(N_REQ): width of grant index (derived, not overridden).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  N_REQ  marks final beat of a burst (used only with lock feature).
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- grant  out  N_REQ  one-hot current grant; all-zero when idle.
- grant_idx  out  IDX_W  binary index of grant (mux select).
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  output register contents.
- out_ready  in  1  downstream accepts out_data.

## Operation
- State ptr (IDX_W bits): highest-priority index; search order ptr, ptr+1, … wrapping mod N_REQ.
- FSM states: IDLE, GRANT.
- IDLE: grant=0, req_ready=0. If any req_valid: register winner (first valid in search order) into grant/grant_idx; go GRANT. Otherwise stay.
- GRANT: req_ready[g] = ~out_valid | out_ready; all other req_ready bits 0.
- Beat transfer: req_valid[g] & req_ready[g]. On transfer, out_data ← req_data[g] and out_valid ← 1.
- Grant release without the lock feature: every transfer ends the grant.
- Grant release with the lock feature: only a transfer with req_last[g]=1 ends the grant.
- On grant end: go IDLE; ptr ← (g+1) mod N_REQ, wrapping from N_REQ-1 to 0; grant cleared next cycle.
- Output register: out_valid clears when out_ready=1 and no new load that cycle. Load and drain in the same cycle keeps out_valid=1 with new data.
- out_data holds its value while out_valid=0 and is never cleared except by reset.
- Requesters must hold req_valid/req_data stable until accepted. With lock, gaps (req_valid[g]=0) inside a burst are allowed and the grant is held.
- Non-granted requesters are never starved: after a grant to g, every other pending requester is served before g again.

## Timing
- Reset (async assert, sync deassert by integrator): out_valid=0, out_data=0, grant=0, grant_idx=0, req_ready=0, ptr=0, FSM=IDLE.
- Reset mid-burst drops the in-flight out_data beat and any partial burst.
- Arbitration latency: req_valid rising in IDLE → grant/req_ready visible the next cycle.
- Beat latency: accepted beat appears on out_valid/out_data the cycle after transfer.
- Throughput without lock: 1 beat per 2 cycles (IDLE+GRANT per beat).
- Throughput with lock: 1 beat/cycle within a burst while out_ready=1.
- out_ready=0 with out_valid=1 stalls: req_ready[g]=0, grant held, no state change.
- req_valid changes of non-granted requesters during GRANT have no effect until the next IDLE.

## Configuration
- MUX_RR_ARBITER_LOCK_EN defined: burst lock. The grant persists across beats until a transfer with req_last=1.
- MUX_RR_ARBITER_LOCK_EN undefined: req_last is ignored and each beat re-arbitrates via IDLE.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 → all outputs 0. Release with only req_valid=4'b0100 → grant=4'b0100 and grant_idx=2 one cycle later; req_data[2]=8'hA5 appears on out_data the next cycle.
- Fairness: all four req_valid=1 continuously, out_ready=1, no lock → grants cycle 0,1,2,3,0; out_data sequence matches requester tags 8'h10,8'h11,8'h12,8'h13,8'h10.
- Wrap: only req_valid[3] and [0] set, ptr=3 → grant 3, then 0, then 3.
- Backpressure: out_ready=0 after first beat → out_valid stays 1, out_data stable, req_ready=0. Raise out_ready → next beat accepted and out_valid never drops for a cycle.
- Lock (MUX_RR_ARBITER_LOCK_EN): requester 1 sends 3 beats with last on the third, and requester 2 is valid throughout → grant stays 4'b0010 for all 3 beats, then moves to 4'b0100.
- Reset mid-burst: assert rst_n=0 during GRANT with out_valid=1 → out_valid=0 and grant=0 immediately (asynchronously); after release, arbitration restarts from ptr=0.
